instr_sequencer: RTL and testbench

- Multi-cycle fetch/decode/issue controller directly upstream of `datapath`.
- Reads 32-bit instructions from a synchronous-read instruction memory and decodes R-type ALU operations.
- Drives the datapath's `rs`, `rt`, `rd`, `alu_control` and `wrReg` inputs, and captures `out_data` as each instruction retires.
- Stops permanently on a HALT instruction; counts retired and illegal instructions for observation.

---
 rtl/instr_sequencer.sv | 119 +++++++++++
 tb/tb_instr_sequencer.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_sequencer.sv
// Fetch/decode/issue controller for an R-type register-file/ALU datapath.
// Legal ALU op: FETCH, DECODE, EXEC, WRITE (4 cycles); illegal op: 2 cycles; HALT is terminal until reset.
module instr_sequencer #(
  parameter int          PC_WIDTH = 8,
  parameter int unsigned START_PC = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [31:0]         imem_data,
  input  logic [31:0]         out_data,
  output logic [PC_WIDTH-1:0] imem_addr,
  output logic                imem_en,
  output logic [3:0]          rs,
  output logic [3:0]          rt,
  output logic [3:0]          rd,
  output logic [3:0]          alu_control,
  output logic                wrReg,
  output logic [31:0]         last_result,
  output logic [15:0]         instr_count,
  output logic [7:0]          illegal_count,
  output logic                busy,
  output logic                halted
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_WRITE, S_HALT
  } state_t;

  state_t              state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [15:0]         sel_q, sel_d;
  logic [31:0]         last_q, last_d;
  logic [15:0]         icnt_q, icnt_d;
  logic [7:0]          ill_q, ill_d;
  logic                en_q, wr_q, busy_q, halted_q;

  logic [3:0] opcode;
  logic       ignored_unused;
  assign opcode         = imem_data[31:28];
  assign ignored_unused = ^imem_data[15:4];

  // sel_q is the decoded IR {rs, rt, rd, funct}; it only reloads on entry to EXEC
  // so the datapath selects stay stable through illegal decodes and HALT.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    sel_d   = sel_q;
    last_d  = last_q;
    icnt_d  = icnt_q;
    ill_d   = ill_q;
    case (state_q)
      S_IDLE:   if (start) state_d = S_FETCH;
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        if (opcode == 4'hF) begin
          state_d = S_HALT;
        end else if (opcode == 4'h0 && !imem_data[3]) begin
          state_d = S_EXEC;
          sel_d   = {imem_data[27:16], imem_data[3:0]};
        end else begin
          state_d = S_FETCH;
          pc_d    = pc_q + 1'b1;
          if (ill_q != 8'hFF) ill_d = ill_q + 8'd1;
        end
      end
      S_EXEC:   state_d = S_WRITE;
      S_WRITE: begin
        state_d = S_FETCH;
        last_d  = out_data;
        pc_d    = pc_q + 1'b1;
        if (icnt_q != 16'hFFFF) icnt_d = icnt_q + 16'd1;
      end
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_IDLE;
    endcase
  end

  // Strobes are registered from the next state so every output comes off a flop.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      pc_q     <= PC_WIDTH'(START_PC);
      sel_q    <= '0;
      last_q   <= '0;
      icnt_q   <= '0;
      ill_q    <= '0;
      en_q     <= 1'b0;
      wr_q     <= 1'b0;
      busy_q   <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      sel_q    <= sel_d;
      last_q   <= last_d;
      icnt_q   <= icnt_d;
      ill_q    <= ill_d;
      en_q     <= (state_d == S_FETCH);
      wr_q     <= (state_d == S_WRITE);
      busy_q   <= (state_d != S_IDLE) && (state_d != S_HALT);
      halted_q <= (state_d == S_HALT);
    end
  end

  assign imem_addr     = pc_q;
  assign imem_en       = en_q;
  assign rs            = sel_q[15:12];
  assign rt            = sel_q[11:8];
  assign rd            = sel_q[7:4];
  assign alu_control   = sel_q[3:0];
  assign wrReg         = wr_q;
  assign last_result   = last_q;
  assign instr_count   = icnt_q;
  assign illegal_count = ill_q;
  assign busy          = busy_q;
  assign halted        = halted_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: two instances (8-bit and 2-bit PC) each driving a behavioural
// register-file/ALU datapath, checked against an instruction-level program model.
module tb_instr_sequencer;

  localparam logic [31:0] HALT_W = 32'hF000_0000;

  typedef struct packed {
    logic        wr;
    logic        en;
    logic        busy;
    logic        halted;
    logic [7:0]  addr;
    logic [15:0] sel;
    logic [31:0] last;
    logic [15:0] ic;
    logic [7:0]  il;
  } obs_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        start_s [2];
  logic [31:0] idat [2];
  logic [31:0] od [2];
  logic [7:0]  a0;
  logic [1:0]  a1;
  logic        en0, en1, wr0, wr1, b0, b1, h0, h1;
  logic [3:0]  rs0, rt0, rd0, al0, rs1, rt1, rd1, al1;
  logic [31:0] lr0, lr1;
  logic [15:0] ic0, ic1;
  logic [7:0]  il0, il1;
  obs_t        o_s [2];

  int n_cmp = 0;
  int n_err = 0;

  instr_sequencer #(.PC_WIDTH(8), .START_PC(0)) u0 (
    .clk(clk), .reset(reset), .start(start_s[0]), .imem_data(idat[0]), .out_data(od[0]),
    .imem_addr(a0), .imem_en(en0), .rs(rs0), .rt(rt0), .rd(rd0), .alu_control(al0),
    .wrReg(wr0), .last_result(lr0), .instr_count(ic0), .illegal_count(il0),
    .busy(b0), .halted(h0));

  instr_sequencer #(.PC_WIDTH(2), .START_PC(0)) u1 (
    .clk(clk), .reset(reset), .start(start_s[1]), .imem_data(idat[1]), .out_data(od[1]),
    .imem_addr(a1), .imem_en(en1), .rs(rs1), .rt(rt1), .rd(rd1), .alu_control(al1),
    .wrReg(wr1), .last_result(lr1), .instr_count(ic1), .illegal_count(il1),
    .busy(b1), .halted(h1));

  function automatic logic [31:0] alu_f(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b);
    case (f)
      4'd0:    alu_f = a + b;
      4'd1:    alu_f = a - b;
      4'd2:    alu_f = a & b;
      4'd3:    alu_f = a | b;
      4'd4:    alu_f = a ^ b;
      4'd5:    alu_f = a << b[4:0];
      4'd6:    alu_f = a >> b[4:0];
      4'd7:    alu_f = {31'b0, a < b};
      default: alu_f = 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] alu_w(input logic [3:0] s, input logic [3:0] t,
                                        input logic [3:0] r, input logic [3:0] f);
    alu_w = {4'h0, s, t, r, 12'($urandom), f};
  endfunction

  // Datapath: combinational ALU on the register file, write at the WRITE edge, R0 protected.
  logic [31:0] rf      [2][16];
  logic [31:0] init_rf [2][16];

  always_comb begin
    od[0]  = alu_f(al0, rf[0][rs0], rf[0][rt0]);
    od[1]  = alu_f(al1, rf[1][rs1], rf[1][rt1]);
    o_s[0] = '{wr0, en0, b0, h0, a0, {rs0, rt0, rd0, al0}, lr0, ic0, il0};
    o_s[1] = '{wr1, en1, b1, h1, {6'b0, a1}, {rs1, rt1, rd1, al1}, lr1, ic1, il1};
  end

  always @(posedge clk) begin
    if (!reset) begin
      for (int d = 0; d < 2; d++)
        for (int r = 0; r < 16; r++)
          rf[d][r] <= (r == 0) ? 32'h0 : init_rf[d][r];
    end else begin
      if (wr0 && rd0 != 4'd0) rf[0][rd0] <= od[0];
      if (wr1 && rd1 != 4'd0) rf[1][rd1] <= od[1];
    end
  end

  // Synchronous-read memory; in wrap mode the 2-bit instance sees HALT when address 0 is revisited.
  logic [31:0] mem [256];
  bit          wrap_mode = 1'b0;
  logic        seen0;

  always @(posedge clk) begin
    if (en0) idat[0] <= mem[a0];
    if (en1) idat[1] <= (wrap_mode && seen0 && a1 == 2'd0) ? HALT_W : mem[{6'b0, a1}];
    if (!reset) seen0 <= 1'b0;
    else if (en1 && a1 == 2'd0) seen0 <= 1'b1;
  end

  task automatic rand_rf(input int d);
    for (int r = 0; r < 16; r++) init_rf[d][r] = $urandom;
  endtask

  task automatic do_reset();
    start_s[0] = 1'b0;
    start_s[1] = 1'b0;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  // Runs the program in mem from PC 0 on instance d, pulsing start at cycles ign1/ign2 (0 = never).
  task automatic run_prog(input int d, input int ign1, input int ign2, input string name);
    logic [31:0] mrf [16];
    logic [31:0] w, res, m_last;
    int exp_k[$];
    logic [15:0] exp_sel[$];
    int exp_fa[$];
    int pc, cyc, m_ic, m_il, halt_k, halt_pc, mask, got, fetches, halt_seen;
    bit vis0, prev_wr;
    obs_t o;

    for (int r = 0; r < 16; r++) mrf[r] = rf[d][r];
    mask = (d == 0) ? 255 : 3;
    pc = 0; cyc = 1; m_ic = 0; m_il = 0; m_last = 0; halt_k = -1; halt_pc = 0; vis0 = 1'b0;
    for (int g = 0; g < 300 && halt_k < 0; g++) begin
      w = mem[pc];
      if (d == 1 && wrap_mode && pc == 0 && vis0) w = HALT_W;
      if (pc == 0) vis0 = 1'b1;
      exp_fa.push_back(pc);
      if (w[31:28] == 4'hF) begin
        halt_k  = cyc + 2;
        halt_pc = pc;
      end else if (w[31:28] == 4'h0 && w[3:0] < 4'd8) begin
        exp_k.push_back(cyc + 3);
        exp_sel.push_back({w[27:16], w[3:0]});
        res = alu_f(w[3:0], mrf[w[27:24]], mrf[w[23:20]]);
        if (w[19:16] != 4'd0) mrf[w[19:16]] = res;
        m_last = res;
        m_ic++;
        pc = (pc + 1) % (mask + 1);
        cyc += 4;
      end else begin
        if (m_il < 255) m_il++;
        pc = (pc + 1) % (mask + 1);
        cyc += 2;
      end
    end

    got = 0; fetches = 0; halt_seen = -1; prev_wr = 1'b0;
    @(negedge clk);
    start_s[d] = 1'b1;
    for (int k = 1; k <= 400; k++) begin
      @(negedge clk);
      start_s[d] = (k == ign1 || k == ign2);
      o = o_s[d];
      if (o.en) begin
        n_cmp++;
        if (fetches >= exp_fa.size() || int'(o.addr) != exp_fa[fetches]) begin
          n_err++;
          $display("FAIL %s fetch_addr: cycle %0d got 0x%0h expected 0x%0h", name, k, o.addr,
                   (fetches < exp_fa.size()) ? exp_fa[fetches] : -1);
        end
        fetches++;
      end
      if (o.wr) begin
        n_cmp++;
        if (got >= exp_k.size()) begin
          n_err++;
          $display("FAIL %s extra_wrReg: cycle %0d sel 0x%0h expected no pulse", name, k, o.sel);
        end else if (k != exp_k[got] || o.sel !== exp_sel[got] || prev_wr) begin
          n_err++;
          $display("FAIL %s wrReg_pulse%0d: got cycle %0d sel 0x%0h prev %0b expected cycle %0d sel 0x%0h prev 0",
                   name, got, k, o.sel, prev_wr, exp_k[got], exp_sel[got]);
        end
        got++;
      end
      prev_wr = o.wr;
      if (o.halted && halt_seen < 0) halt_seen = k;
      if (halt_seen > 0 && k >= halt_seen + 4 && k > ign2) break;
    end

    o = o_s[d];
    n_cmp++;
    if (got != exp_k.size() || halt_seen != halt_k) begin
      n_err++;
      $display("FAIL %s pulses_halt: got %0d pulses halt@%0d expected %0d pulses halt@%0d",
               name, got, halt_seen, exp_k.size(), halt_k);
    end
    n_cmp++;
    if (o.ic !== 16'(m_ic) || o.il !== 8'(m_il)) begin
      n_err++;
      $display("FAIL %s counters: got instr %0d illegal %0d expected instr %0d illegal %0d",
               name, o.ic, o.il, m_ic, m_il);
    end
    n_cmp++;
    if (o.last !== m_last) begin
      n_err++;
      $display("FAIL %s last_result: got 0x%0h expected 0x%0h", name, o.last, m_last);
    end
    n_cmp++;
    if ({o.halted, o.busy, o.wr, o.en} !== 4'b1000 || int'(o.addr) != halt_pc) begin
      n_err++;
      $display("FAIL %s final_state: got halted %0b busy %0b wr %0b en %0b pc 0x%0h expected 1 0 0 0 pc 0x%0h",
               name, o.halted, o.busy, o.wr, o.en, o.addr, halt_pc);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    start_s[0] = 1'b0;
    start_s[1] = 1'b0;
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      n_cmp++;
      if (o_s[d] !== '0) begin
        n_err++;
        $display("FAIL reset_state%0d: got 0x%0h expected 0", d, o_s[d]);
      end
    end
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({o_s[0].busy, o_s[0].en, o_s[0].wr, o_s[0].halted} !== 4'b0000) begin
      n_err++;
      $display("FAIL idle_hold: got busy/en/wr/halted %b expected 0000",
               {o_s[0].busy, o_s[0].en, o_s[0].wr, o_s[0].halted});
    end
  endtask

  task automatic test_add_halt();
    wrap_mode = 1'b0;
    rand_rf(0);
    init_rf[0][1] = 32'd1;
    init_rf[0][2] = 32'd2;
    mem[0] = alu_w(4'd1, 4'd2, 4'd3, 4'd0);
    mem[1] = HALT_W;
    do_reset();
    run_prog(0, 0, 0, "add_halt");
    n_cmp++;
    if (o_s[0].last !== 32'h3 || o_s[0].addr !== 8'd1) begin
      n_err++;
      $display("FAIL add_halt_abs: got last 0x%0h pc %0d expected last 0x3 pc 1", o_s[0].last, o_s[0].addr);
    end
  endtask

  task automatic test_alu8();
    wrap_mode = 1'b0;
    rand_rf(0);
    for (int i = 0; i < 8; i++)
      mem[i] = alu_w(4'($urandom), 4'($urandom), 4'($urandom), 4'(i));
    mem[8] = HALT_W;
    do_reset();
    run_prog(0, 0, 0, "alu8");
  endtask

  task automatic test_illegal();
    wrap_mode = 1'b0;
    rand_rf(0);
    mem[0] = {4'h5, 28'($urandom)};
    mem[1] = alu_w(4'($urandom), 4'($urandom), 4'($urandom), 4'h9);
    mem[2] = HALT_W;
    do_reset();
    run_prog(0, 0, 0, "illegal");
  endtask

  task automatic test_reset_mid();
    wrap_mode = 1'b0;
    rand_rf(0);
    for (int i = 0; i < 8; i++)
      mem[i] = alu_w(4'($urandom), 4'($urandom), 4'($urandom_range(1, 15)), 4'(i));
    mem[8] = HALT_W;
    do_reset();
    @(negedge clk);
    start_s[0] = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      start_s[0] = 1'b0;
    end
    // cycle 11 is EXEC of the third instruction
    n_cmp++;
    if (o_s[0].ic !== 16'd2 || o_s[0].busy !== 1'b1 || o_s[0].wr !== 1'b0) begin
      n_err++;
      $display("FAIL pre_reset_exec: got instr %0d busy %0b wr %0b expected 2 1 0", o_s[0].ic, o_s[0].busy, o_s[0].wr);
    end
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    n_cmp++;
    if (o_s[0] !== '0) begin
      n_err++;
      $display("FAIL reset_mid_state: got 0x%0h expected 0", o_s[0]);
    end
    run_prog(0, 0, 0, "rerun_after_reset");
  endtask

  task automatic test_wrap();
    wrap_mode = 1'b1;
    rand_rf(1);
    for (int i = 0; i < 4; i++)
      mem[i] = alu_w(4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom_range(0, 7)));
    do_reset();
    run_prog(1, 0, 0, "wrap");
    n_cmp++;
    if (o_s[1].ic !== 16'd4 || o_s[1].addr !== 8'd0) begin
      n_err++;
      $display("FAIL wrap_abs: got instr %0d pc %0d expected 4 0", o_s[1].ic, o_s[1].addr);
    end
    wrap_mode = 1'b0;
  endtask

  task automatic test_rd0_start_ignored();
    wrap_mode = 1'b0;
    rand_rf(0);
    mem[0] = alu_w(4'd1, 4'd2, 4'd0, 4'd0);
    mem[1] = HALT_W;
    do_reset();
    run_prog(0, 3, 9, "rd0_start_ignored");
  endtask

  task automatic test_random();
    int n, c;
    for (int p = 0; p < 4; p++) begin
      wrap_mode = 1'b0;
      rand_rf(0);
      n = $urandom_range(4, 12);
      for (int i = 0; i < n; i++) begin
        c = $urandom_range(0, 9);
        if (c < 7)       mem[i] = alu_w(4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom_range(0, 7)));
        else if (c == 7) mem[i] = alu_w(4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom_range(8, 15)));
        else             mem[i] = {4'($urandom_range(1, 14)), 28'($urandom)};
      end
      mem[n] = HALT_W;
      do_reset();
      run_prog(0, $urandom_range(2, 20), $urandom_range(21, 60), "random");
    end
  endtask

  initial begin
    reset = 1'b0;
    start_s[0] = 1'b0;
    start_s[1] = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = HALT_W;
    for (int d = 0; d < 2; d++) rand_rf(d);
    test_reset();
    test_add_halt();
    test_alu8();
    test_illegal();
    test_reset_mid();
    test_wrap();
    test_rd0_start_ignored();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
